// File: rtl/shift_arbiter.sv
// shift_arbiter
// Two requesters (port 0 = ALU execute, port 1 = multdiv) share one
// 32-bit shifter. The shifter supports logical left and arithmetic right.
// Arbitration uses valid/ready handshakes. The winner's result lands in a
// single registered response slot, tagged with the winning port.
//
// Build option:
//   SHIFT_ARB_ROUND_ROBIN_EN
//     defined   : when both ports are valid, the winner is chosen by a
//                 round-robin pointer.
//     undefined : fixed priority to port 0. Port 1 may starve, and the
//                 busy counter records the starved cycles.
module shift_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_amt,
    input  logic        req0_dir,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_amt,
    input  logic        req1_dir,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic [7:0]  busy_cnt
);

    // Five-stage barrel shifter: shift by 1, 2, 4, 8 and 16.
    // A left shift fills with zeros. An arithmetic right shift fills with
    // the operand's sign bit (bit 31).
    function automatic logic [31:0] barrel_shift(
        input logic [31:0] data,
        input logic [4:0]  amt,
        input logic        dir
    );
        logic [31:0] v;
        logic        fill;
        v    = data;
        fill = dir & data[31];
        if (amt[0]) begin
            if (dir) v = {fill, v[31:1]};
            else     v = {v[30:0], 1'b0};
        end
        if (amt[1]) begin
            if (dir) v = {{2{fill}}, v[31:2]};
            else     v = {v[29:0], 2'b00};
        end
        if (amt[2]) begin
            if (dir) v = {{4{fill}}, v[31:4]};
            else     v = {v[27:0], 4'h0};
        end
        if (amt[3]) begin
            if (dir) v = {{8{fill}}, v[31:8]};
            else     v = {v[23:0], 8'h00};
        end
        if (amt[4]) begin
            if (dir) v = {{16{fill}}, v[31:16]};
            else     v = {v[15:0], 16'h0000};
        end
        return v;
    endfunction

    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        if (cnt == 8'd255) return 8'd255;
        else               return cnt + 8'd1;
    endfunction

    logic        rsp_valid_r;
    logic        rsp_id_r;
    logic [31:0] rsp_data_r;
    logic [7:0]  busy_cnt_r;

    logic        can_accept_s;
    logic        grant_vld_s;
    logic        grant_id_s;
    logic        xfer_s;
    logic        refused_s;
    logic [31:0] sel_data_s;
    logic [4:0]  sel_amt_s;
    logic        sel_dir_s;
    logic [31:0] shift_res_s;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    logic        ptr_r;
    logic        both_valid_s;
    assign both_valid_s = req0_valid & req1_valid;
`endif

    // The slot can take a new result if it is empty or is being drained now.
    assign can_accept_s = ~rsp_valid_r | rsp_ready;

    // Choose the winning port. No grant is made while reset is high.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        if (reset) begin
            grant_vld_s = 1'b0;
            grant_id_s  = 1'b0;
        end else begin
            case ({req1_valid, req0_valid})
                2'b01: begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = 1'b0;
                end
                2'b10: begin
                    grant_vld_s = 1'b1;
                    grant_id_s  = 1'b1;
                end
                2'b11: begin
                    grant_vld_s = 1'b1;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
                    grant_id_s  = ptr_r;
`else
                    grant_id_s  = 1'b0;
`endif
                end
                default: begin
                    grant_vld_s = 1'b0;
                    grant_id_s  = 1'b0;
                end
            endcase
        end
    end

    assign xfer_s     = grant_vld_s & can_accept_s;
    assign req0_ready = xfer_s & (grant_id_s == 1'b0);
    assign req1_ready = xfer_s & (grant_id_s == 1'b1);
    assign refused_s  = (req0_valid & ~req0_ready) | (req1_valid & ~req1_ready);

    // Steer the winning port's payload into the shared shifter.
    always_comb begin
        sel_data_s = req0_data;
        sel_amt_s  = req0_amt;
        sel_dir_s  = req0_dir;
        if (grant_id_s) begin
            sel_data_s = req1_data;
            sel_amt_s  = req1_amt;
            sel_dir_s  = req1_dir;
        end else begin
            sel_data_s = req0_data;
            sel_amt_s  = req0_amt;
            sel_dir_s  = req0_dir;
        end
    end

    assign shift_res_s = barrel_shift(sel_data_s, sel_amt_s, sel_dir_s);

    // Response slot: load on transfer, empty on consume, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_data_r  <= 32'h0000_0000;
        end else if (xfer_s) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= grant_id_s;
            rsp_data_r  <= shift_res_s;
        end else if (rsp_valid_r & rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    // After a contested transfer, the losing port gets priority next time.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (xfer_s & both_valid_s) begin
            ptr_r <= ~grant_id_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`endif

    // Count cycles in which some valid request was turned away. The count
    // saturates at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_cnt_r <= 8'd0;
        end else if (refused_s) begin
            busy_cnt_r <= sat_inc8(busy_cnt_r);
        end else begin
            busy_cnt_r <= busy_cnt_r;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign busy_cnt  = busy_cnt_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter. Expected values are hand-computed.
// Expectations for the contention test depend on SHIFT_ARB_ROUND_ROBIN_EN.
module tb_shift_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_dir;
    logic [31:0] req0_data;
    logic [4:0]  req0_amt;
    logic        req1_valid, req1_ready, req1_dir;
    logic [31:0] req1_data;
    logic [4:0]  req1_amt;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_data;
    logic [7:0]  busy_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_busy = 0;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    localparam int NCONT = 4;
`else
    localparam int NCONT = 260;
`endif

    shift_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_amt   (req0_amt),
        .req0_dir   (req0_dir),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_amt   (req1_amt),
        .req1_dir   (req1_dir),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy_cnt   (busy_cnt)
    );

    // 10-time-unit clock.
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int busy_next(input int b);
        return (b >= 255) ? 255 : b + 1;
    endfunction

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0; req0_data = 32'h0; req0_amt = 5'd0; req0_dir = 1'b0;
        req1_valid = 1'b0; req1_data = 32'h0; req1_amt = 5'd0; req1_dir = 1'b0;
        rsp_ready  = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rst_id",    {31'b0, rsp_id},    32'd0);
        check_eq("rst_data",  rsp_data,           32'h0);
        check_eq("rst_busy",  {24'b0, busy_cnt},  32'd0);
        check_eq("rst_rdy0",  {31'b0, req0_ready}, 32'd0);
        check_eq("rst_rdy1",  {31'b0, req1_ready}, 32'd0);

        // Single left shift by 31.
        req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_amt = 5'd31; req0_dir = 1'b0;
        #1;
        check_eq("t1_rdy0", {31'b0, req0_ready}, 32'd1);
        check_eq("t1_rdy1", {31'b0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        check_eq("t1_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("t1_id",    {31'b0, rsp_id},    32'd0);
        check_eq("t1_data",  rsp_data,           32'h8000_0000);

        // Arithmetic right shift by 4 on port 1.
        req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_amt = 5'd4; req1_dir = 1'b1;
        #1;
        check_eq("t2_rdy1", {31'b0, req1_ready}, 32'd1);
        step();
        check_eq("t2_id",   {31'b0, rsp_id}, 32'd1);
        check_eq("t2_data", rsp_data,        32'hF800_0000);
        // Pass-through with amount 0.
        req1_data = 32'h1234_5678; req1_amt = 5'd0;
        step();
        check_eq("t2_pass", rsp_data, 32'h1234_5678);
        // Arithmetic right by 31 of a negative operand.
        req1_data = 32'h8000_0001; req1_amt = 5'd31;
        step();
        check_eq("t2_sra31", rsp_data, 32'hFFFF_FFFF);
        // Arithmetic right of a positive operand fills with zeros.
        req1_data = 32'h7000_0000; req1_amt = 5'd3;
        step();
        check_eq("t2_sra_pos", rsp_data, 32'h0E00_0000);
        // Drain the slot; data and id must stay the same.
        req1_valid = 1'b0;
        step();
        check_eq("drain_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("drain_data",  rsp_data,           32'h0E00_0000);
        check_eq("drain_id",    {31'b0, rsp_id},    32'd1);
        check_eq("drain_busy",  {24'b0, busy_cnt},  32'd0);

        // Contention: both ports valid, rsp_ready=1.
        req0_valid = 1'b1; req0_data = 32'h1; req0_amt = 5'd1; req0_dir = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h1; req1_amt = 5'd2; req1_dir = 1'b0;
        for (int i = 0; i < NCONT; i++) begin
            logic g;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            g = (i % 2 == 1);
`else
            g = 1'b0;
`endif
            #1;
            if (i < 4) begin
                check_eq("cont_rdy0", {31'b0, req0_ready}, {31'b0, ~g});
                check_eq("cont_rdy1", {31'b0, req1_ready}, {31'b0, g});
            end
            exp_busy = busy_next(exp_busy);
            step();
            if (i < 4) begin
                check_eq("cont_id",   {31'b0, rsp_id},   {31'b0, g});
                check_eq("cont_data", rsp_data,          g ? 32'h4 : 32'h2);
                check_eq("cont_busy", {24'b0, busy_cnt}, exp_busy);
            end
        end
        check_eq("cont_busy_end", {24'b0, busy_cnt}, exp_busy);
        check_eq("cont_rdy1_end", {31'b0, req1_ready},
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
                 32'd0);
`else
                 32'd0);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Back-pressure: fill the slot with 0xF0 << 4.
        req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_amt = 5'd4; req0_dir = 1'b0;
        #1;
        check_eq("bp_fill_rdy0", {31'b0, req0_ready}, 32'd1);
        step();
        req0_amt  = 5'd8;
        rsp_ready = 1'b0;
        check_eq("bp_fill_data", rsp_data, 32'h0000_0F00);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("bp_rdy0", {31'b0, req0_ready}, 32'd0);
            exp_busy = busy_next(exp_busy);
            step();
            check_eq("bp_data",  rsp_data,           32'h0000_0F00);
            check_eq("bp_valid", {31'b0, rsp_valid}, 32'd1);
        end
        check_eq("bp_busy", {24'b0, busy_cnt}, exp_busy);
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_rel_rdy0", {31'b0, req0_ready}, 32'd1);
        step();
        check_eq("bp_rel_data", rsp_data, 32'h0000_F000);

        // Reset while FULL, with a request pending.
        rsp_ready = 1'b0;
        req0_data = 32'h3; req0_amt = 5'd1; req0_dir = 1'b0;
        reset = 1'b1;
        #1;
        check_eq("rf_rdy0", {31'b0, req0_ready}, 32'd0);
        check_eq("rf_rdy1", {31'b0, req1_ready}, 32'd0);
        step();
        check_eq("rf_valid", {31'b0, rsp_valid}, 32'd0);
        check_eq("rf_data",  rsp_data,           32'h0);
        check_eq("rf_busy",  {24'b0, busy_cnt},  32'd0);
        reset = 1'b0;
        #1;
        check_eq("rf_post_rdy0", {31'b0, req0_ready}, 32'd1);
        step();
        check_eq("rf_post_valid", {31'b0, rsp_valid}, 32'd1);
        check_eq("rf_post_data",  rsp_data,           32'h6);
        check_eq("rf_post_id",    {31'b0, rsp_id},    32'd0);
        req0_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit shift datapath (logical left / arithmetic right, 5-bit amount) between two requesters in the processor: port 0 is the ALU execute stage and port 1 is the multdiv unit. It arbitrates valid/ready requests, computes the shift, and holds the result in a single registered response slot that is tagged with the winning port. It is a single-clock block with one pipeline register, and throughput is one shift per cycle while the consumer accepts.

## Interface
- No parameters. Data width is fixed at 32 and the shift amount at 5 bits.
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 has a request
- req0_ready  out  1  port 0 request accepted this cycle
- req0_data  in  32  port 0 operand
- req0_amt  in  5  port 0 shift amount, 0..31
- req0_dir  in  1  port 0 direction: 0 = logical left, 1 = arithmetic right
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same widths and meanings for port 1
- rsp_valid  out  1  response slot holds a result
- rsp_ready  in  1  consumer takes the result this cycle
- rsp_id  out  1  port that issued the held result
- rsp_data  out  32  shifted result
- busy_cnt  out  8  saturating count of cycles in which a valid request was refused

## Operation
- The response slot has two states. EMPTY means rsp_valid=0. FULL means rsp_valid=1.
- can_accept = !rsp_valid | rsp_ready.
- Grant rules:
  - Only one request is granted per cycle, and only when can_accept=1.
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port selected by the priority pointer `ptr` is granted.
- reqN_ready = can_accept & grant==N. This is combinational from the valids, `ptr`, rsp_valid and rsp_ready. reqN_ready is never asserted for a port whose reqN_valid=0.
- On a transfer (reqN_valid & reqN_ready):
  - rsp_data is loaded with the shift of reqN_data by reqN_amt.
  - rsp_id is loaded with N.
  - The slot goes to FULL.
- Left shift fills with zeros. Right shift replicates bit 31.
- Amount 0 passes data through unchanged. Amount 31 left gives {data[0], 31'b0}. Amount 31 right gives 32 copies of data[31].
- Without a transfer:
  - If rsp_valid & rsp_ready, the slot goes to EMPTY. rsp_data and rsp_id keep their last values.
  - Otherwise the slot holds. rsp_data and rsp_id do not change while FULL.
- When a result is consumed and a new request is accepted in the same cycle, the new result is loaded and the slot stays FULL.
- `ptr` (round-robin mode): after every transfer in which both ports were valid, `ptr` moves to the port that lost. Otherwise `ptr` is unchanged.
- busy_cnt: increments by 1 in each cycle where (req0_valid & !req0_ready) | (req1_valid & !req1_ready). It saturates at 255.
- Requesters must hold valid and all payload fields stable until ready. The block does not check this.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, ptr=0, busy_cnt=0. Therefore req0_ready and req1_ready are 0 unless a valid is high. After reset, req0_ready may be 1 in the first cycle if req0_valid=1.
- Latency: a request accepted at edge T has its result visible with rsp_valid=1 in the cycle after T.
- Throughput: one transfer per cycle while rsp_ready=1.
- Back-pressure: with rsp_valid=1 and rsp_ready=0, both readys are 0 and the result is held indefinitely.
- Reset mid-operation: asserting reset while FULL discards the held result. In the reset cycle itself, no request is granted and both readys are 0. The pending requester must keep its valid high and is served after reset deasserts.
- There are no combinational paths from rsp_ready to rsp_data or rsp_id.

## Configuration
- Macro: SHIFT_ARB_ROUND_ROBIN_EN.
- When defined, arbitration uses round robin through `ptr` as described above.
- When undefined, priority is fixed to port 0 whenever both ports are valid. `ptr` is not implemented. Port 1 can starve, and busy_cnt counts those starved cycles.

## Test plan
- Single left shift. After reset, req0 sends data=0x0000_0001, amt=31, dir=0. Required: req0_ready=1 in that cycle. In the next cycle, rsp_valid=1, rsp_id=0, rsp_data=0x8000_0000.
- Arithmetic right shift and pass-through. req1 sends data=0x8000_0000, amt=4, dir=1: required rsp_data=0xF800_0000, rsp_id=1. Then req1 sends data=0x1234_5678, amt=0: required rsp_data=0x1234_5678.
- Contention, round-robin build. Both ports are valid every cycle and rsp_ready=1. Required grants: 0, 1, 0, 1, and rsp_id alternates the same way one cycle later. busy_cnt increments by 1 each cycle.
- Contention, fixed-priority build. Same stimulus as above. Required: every grant goes to port 0, req1_ready stays 0, and busy_cnt reaches 255 and holds there.
- Back-pressure. Fill the slot with 0x0000_00F0 << 4, then hold rsp_ready=0 for 5 cycles while req0 is valid. Required: req0_ready=0 for all 5 cycles and rsp_data=0x0000_0F00 stable. When rsp_ready=1, the new request is loaded in that same cycle.
- Reset while FULL. Assert reset while rsp_valid=1. Required in the next cycle: rsp_valid=0, rsp_data=0, busy_cnt=0. The held request is granted in the first cycle after reset deasserts.
